// File: rtl/vram_row_reader.sv
// VRAM frame scanner: fetches one 512-bit row at a time into a local row buffer
// and streams its pixels over a valid/ready interface, row by row, for one frame.
module vram_row_reader #(
    parameter int ROWS        = 64,
    parameter int PIX_W       = 8,
    parameter int PIX_PER_ROW = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         vram_rd,
    output logic [5:0]                   vram_rd_addr,
    input  logic [PIX_W*PIX_PER_ROW-1:0] vram_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [PIX_W-1:0]             pix_data,
    output logic [5:0]                   pix_x,
    output logic [5:0]                   pix_y,
    output logic                         pix_eol,
    output logic                         pix_eof
);

    localparam int         ROW_BITS = PIX_W * PIX_PER_ROW;
    localparam logic [5:0] LAST_COL = 6'(PIX_PER_ROW - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            row_q, row_d;
    logic [5:0]            col_q, col_d;
    logic [ROW_BITS-1:0]   buf_q, buf_d;

    // State, counters and row buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 6'd0;
            col_q   <= 6'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state logic; the row counter stays at the last row after DONE until the next start
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = 6'd0;
                    col_d   = 6'd0;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                buf_d   = vram_data;
                col_d   = 6'd0;
                state_d = STREAM;
            end
            STREAM: begin
                if (pix_ready) begin
                    if (col_q != LAST_COL) begin
                        col_d = col_q + 6'd1;
                    end else if (row_q != LAST_ROW) begin
                        row_d   = row_q + 6'd1;
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q == REQ) || (state_q == WAIT) || (state_q == STREAM);
    assign frame_done   = (state_q == DONE);
    assign vram_rd      = (state_q == REQ);
    assign vram_rd_addr = row_q;

    // Pixel outputs come only from the row buffer, so VRAM changes mid-row are invisible
    assign pix_valid = (state_q == STREAM);
    assign pix_data  = buf_q[PIX_W*int'(col_q) +: PIX_W];
    assign pix_x     = col_q;
    assign pix_y     = row_q;
    assign pix_eol   = pix_valid && (col_q == LAST_COL);
    assign pix_eof   = pix_valid && (col_q == LAST_COL) && (row_q == LAST_ROW);

endmodule

// File: tb/tb_vram_row_reader.sv
// Directed bench for vram_row_reader with a registered-read VRAM model.
module tb_vram_row_reader;

    logic         clk, rst, start, busy, frame_done, vram_rd;
    logic [5:0]   vram_rd_addr;
    logic [511:0] vram_data;
    logic         pix_valid, pix_ready, pix_eol, pix_eof;
    logic [7:0]   pix_data;
    logic [5:0]   pix_x, pix_y;

    logic [511:0] mem [0:63];

    int chk = 0;
    int pass = 0;
    int xfers, rd_cnt, done_cyc, first_rd_cyc, first_valid_cyc, eol0_cyc, rd2_cyc;
    logic       done_busy;
    logic [5:0] first_rd_addr, rd2_addr;
    logic [7:0] eol0_data;
    int inv_row = -1;
    int trig_row = -1;

    vram_row_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .vram_rd(vram_rd), .vram_rd_addr(vram_rd_addr), .vram_data(vram_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_rd) vram_data <= mem[vram_rd_addr];
    end

    function automatic logic [511:0] row_pat(input int r);
        logic [511:0] p;
        for (int c = 0; c < 64; c++) p[c*8 +: 8] = 8'(r ^ c);
        return p;
    endfunction

    task automatic fill_mem();
        for (int r = 0; r < 64; r++) mem[r] = row_pat(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start in the current cycle and checks every transfer and stall until frame_done.
    task automatic run_frame(input int rdy_pct, input bit spam);
        int cyc, ex, ey;
        bit stall;
        logic [21:0] saved;
        logic [7:0]  expd;
        xfers = 0; rd_cnt = 0; done_cyc = -1; first_rd_cyc = -1; first_valid_cyc = -1;
        eol0_cyc = -1; rd2_cyc = -1; ex = 0; ey = 0; stall = 1'b0; saved = '0;
        start = 1'b1;
        pix_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 30000) begin
            pix_ready = ($urandom_range(0, 99) < rdy_pct);
            start = spam && (cyc == 10 || cyc == 500);
            if (vram_rd) begin
                rd_cnt++;
                if (rd_cnt == 1) begin first_rd_cyc = cyc; first_rd_addr = vram_rd_addr; end
                if (rd_cnt == 2) begin rd2_cyc = cyc; rd2_addr = vram_rd_addr; end
            end
            if (stall) begin
                chk++;
                if (pix_valid === 1'b1 && {pix_data, pix_x, pix_y, pix_eol, pix_eof} === saved) pass++;
                else $display("FAIL stall_hold cyc=%0d got valid=%b out=%h exp out=%h", cyc, pix_valid, {pix_data, pix_x, pix_y, pix_eol, pix_eof}, saved);
            end
            stall = 1'b0;
            if (pix_valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (!pix_ready) begin
                    stall = 1'b1;
                    saved = {pix_data, pix_x, pix_y, pix_eol, pix_eof};
                end else begin
                    expd = 8'(ex ^ ey);
                    if (ey == inv_row) expd = ~expd;
                    chk++;
                    if (pix_x === ex[5:0] && pix_y === ey[5:0] && pix_data === expd &&
                        pix_eol === (ex == 63) && pix_eof === (ex == 63 && ey == 63)) pass++;
                    else $display("FAIL pixel cyc=%0d got x=%0d y=%0d d=%h eol=%b eof=%b exp x=%0d y=%0d d=%h",
                                  cyc, pix_x, pix_y, pix_data, pix_eol, pix_eof, ex, ey, expd);
                    if (ex == 63 && ey == 0) begin eol0_cyc = cyc; eol0_data = pix_data; end
                    if (ey == trig_row && ex == 10) mem[ey] = ~row_pat(ey);
                    xfers++;
                    if (ex == 63) begin ex = 0; ey++; end
                    else ex++;
                end
            end
            if (frame_done === 1'b1) begin
                done_cyc = cyc;
                done_busy = busy;
                if (spam) start = 1'b1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pix_ready = 1'b1;
        repeat (3) tick();
        chk++;
        if ({busy, frame_done, vram_rd, vram_rd_addr, pix_valid, pix_x, pix_y, pix_data, pix_eol, pix_eof} === 32'h0) pass++;
        else $display("FAIL reset_outputs got %h exp 0", {busy, frame_done, vram_rd, vram_rd_addr, pix_valid, pix_x, pix_y, pix_data, pix_eol, pix_eof});
        rst = 1'b0; start = 1'b0;
        tick();
        chk++;
        if (busy === 1'b0 && vram_rd === 1'b0) pass++;
        else $display("FAIL start_during_rst got busy=%b rd=%b exp 0 0", busy, vram_rd);
    endtask

    task automatic test_full_frame();
        fill_mem();
        run_frame(100, 1'b0);
        chk++; if (first_rd_cyc == 1 && first_rd_addr === 6'd0) pass++; else $display("FAIL first_rd got cyc=%0d addr=%0d exp 1 0", first_rd_cyc, first_rd_addr);
        chk++; if (first_valid_cyc == 3) pass++; else $display("FAIL first_valid got %0d exp 3", first_valid_cyc);
        chk++; if (eol0_cyc == 66 && eol0_data === 8'h3F) pass++; else $display("FAIL row0_eol got cyc=%0d d=%h exp 66 3f", eol0_cyc, eol0_data);
        chk++; if (rd2_cyc == 67 && rd2_addr === 6'd1) pass++; else $display("FAIL second_rd got cyc=%0d addr=%0d exp 67 1", rd2_cyc, rd2_addr);
        chk++; if (xfers == 4096) pass++; else $display("FAIL full_xfers got %0d exp 4096", xfers);
        chk++; if (done_cyc == 4225) pass++; else $display("FAIL full_done_cyc got %0d exp 4225", done_cyc);
        chk++; if (done_busy === 1'b0) pass++; else $display("FAIL busy_at_done got %b exp 0", done_busy);
        chk++; if (rd_cnt == 64) pass++; else $display("FAIL full_rd_cnt got %0d exp 64", rd_cnt);
        chk++; if (frame_done === 1'b0 && busy === 1'b0) pass++; else $display("FAIL done_single got fd=%b busy=%b exp 0 0", frame_done, busy);
    endtask

    task automatic test_backpressure();
        run_frame(30, 1'b0);
        chk++; if (xfers == 4096) pass++; else $display("FAIL bp_xfers got %0d exp 4096", xfers);
        chk++; if (done_cyc > 4225) pass++; else $display("FAIL bp_done got cyc %0d exp >4225", done_cyc);
        chk++; if (rd_cnt == 64) pass++; else $display("FAIL bp_rd_cnt got %0d exp 64", rd_cnt);
    endtask

    task automatic test_ignored_start();
        int bad;
        run_frame(100, 1'b1);
        chk++; if (rd_cnt == 64) pass++; else $display("FAIL ign_rd_cnt got %0d exp 64", rd_cnt);
        chk++; if (done_cyc == 4225) pass++; else $display("FAIL ign_done_cyc got %0d exp 4225", done_cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (vram_rd !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        chk++; if (bad == 0) pass++; else $display("FAIL ign_restart got %0d active cycles exp 0", bad);
    endtask

    task automatic test_reset_mid();
        int n;
        start = 1'b1; pix_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(pix_valid === 1'b1 && pix_y === 6'd5 && pix_x === 6'd20) && n < 1000) begin tick(); n++; end
        chk++; if (n < 1000) pass++; else $display("FAIL mid_reach got timeout exp row5 col20");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk++;
        if (pix_valid === 1'b0 && busy === 1'b0 && frame_done === 1'b0 && pix_x === 6'd0 && pix_y === 6'd0) pass++;
        else $display("FAIL mid_abort got v=%b busy=%b fd=%b x=%0d y=%0d exp 0", pix_valid, busy, frame_done, pix_x, pix_y);
        run_frame(100, 1'b0);
        chk++; if (xfers == 4096 && done_cyc == 4225) pass++; else $display("FAIL mid_rescan got xfers=%0d done=%0d exp 4096 4225", xfers, done_cyc);
    endtask

    task automatic test_row_isolation();
        fill_mem();
        trig_row = 2;
        run_frame(100, 1'b0);
        trig_row = -1;
        chk++; if (xfers == 4096) pass++; else $display("FAIL iso_xfers got %0d exp 4096", xfers);
        inv_row = 2;
        run_frame(100, 1'b0);
        inv_row = -1;
        chk++; if (xfers == 4096) pass++; else $display("FAIL iso_next_xfers got %0d exp 4096", xfers);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        fill_mem();
        test_reset();
        test_full_frame();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_row_isolation();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
